// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request, response and memory-side signals of the IF/MEM memory port arbiter.
// Rev 1.0
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_ack;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ack;
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ready;
  logic                 stall_if;
  logic                 stall_mem;
  logic                 mem_err;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ack, d_rdata, d_ack, mem_read, mem_write, mem_addr, mem_wdata,
           stall_if, stall_mem, mem_err
  );

  // Pipeline stages and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_read, mem_write, mem_addr, mem_wdata,
           stall_if, stall_mem, mem_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data access.
// Rev 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 4
) (
  input  wire                     Clk,
  input  wire                     Reset,
  mem_port_arbiter_if.slave       bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IBUSY = 2'd1;
  localparam logic [1:0] S_DBUSY = 2'd2;

  // Counter value at which the current busy cycle is the last one allowed.
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic                 r_i_ack;
  logic                 r_d_ack;
  logic                 r_mem_err;

  logic w_d_elig;
  logic w_i_elig;
  logic w_cnt_last;

  assign w_d_elig   = bus.d_req & ~r_d_ack;
  assign w_i_elig   = bus.i_req & ~r_i_ack;
  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // Data side wins ties: the MEM-stage instruction is older than the fetch.
          if (w_d_elig) begin
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_mem_read  <= ~bus.d_we;
            r_mem_write <= bus.d_we;
            r_state     <= S_DBUSY;
          end else if (w_i_elig) begin
            r_mem_addr  <= bus.i_addr;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_state     <= S_IBUSY;
          end
        end
        S_IBUSY, S_DBUSY: begin
          if (bus.mem_ready) begin
            if (r_state == S_IBUSY) begin
              r_i_rdata <= bus.mem_rdata;
              r_i_ack   <= 1'b1;
            end else begin
              if (!r_mem_write) begin
                r_d_rdata <= bus.mem_rdata;
              end
              r_d_ack <= 1'b1;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else if (w_cnt_last) begin
            // Abort: ack still pulses so the requester unfreezes, with mem_err flagging bad data.
            r_i_ack     <= (r_state == S_IBUSY);
            r_d_ack     <= (r_state == S_DBUSY);
            r_mem_err   <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.i_ack     = r_i_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.mem_err   = r_mem_err;
  assign bus.stall_if  = bus.i_req & ~r_i_ack;
  assign bus.stall_mem = bus.d_req & ~r_d_ack;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, hand sequences and randomized accesses against a transaction model.
// Rev 1.0
`default_nettype none

module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;
  logic [15:0] exp_i_rdata;
  logic [15:0] exp_d_rdata;

  mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

  mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT(TO), .CNT_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          do_i;
    bit          do_d;
    bit          d_we;
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] rd_i;
    logic [15:0] rd_d;
    int          dly_i;
    int          dly_d;
    int          exp_busy_i;
    int          exp_busy_d;
    bit          exp_err_i;
    bit          exp_err_d;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Model: memory answers after dly idle busy cycles; the port gives up after TO busy cycles.
  function automatic int model_busy(input int dly);
    return (dly + 1 > TO) ? TO : dly + 1;
  endfunction

  function automatic bit model_err(input int dly);
    return (dly >= TO);
  endfunction

  function automatic vec_t mk(input bit di, input bit dd, input bit we,
                              input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                              input logic [15:0] ri, input logic [15:0] rd,
                              input int dli, input int dld,
                              input int bi, input int bd, input bit ei, input bit ed);
    vec_t v;
    v.do_i = di; v.do_d = dd; v.d_we = we;
    v.i_addr = ia; v.d_addr = da; v.d_wdata = wd;
    v.rd_i = ri; v.rd_d = rd; v.dly_i = dli; v.dly_d = dld;
    v.exp_busy_i = bi; v.exp_busy_d = bd; v.exp_err_i = ei; v.exp_err_d = ed;
    return v;
  endfunction

  // Entered and left at #1 after a posedge with the arbiter idle and no ack pending.
  task automatic run_vec(input vec_t v);
    int          n;
    bit          is_d;
    bit          is_st;
    bit          err;
    int          busy;
    int          dly;
    logic [15:0] rd;
    logic [15:0] addr;
    bus.i_req   = v.do_i;
    bus.i_addr  = v.i_addr;
    bus.d_req   = v.do_d;
    bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
    n = int'(v.do_i) + int'(v.do_d);
    for (int k = 0; k < n; k++) begin
      is_d  = v.do_d && (k == 0);
      is_st = is_d && v.d_we;
      busy  = is_d ? v.exp_busy_d : v.exp_busy_i;
      err   = is_d ? v.exp_err_d : v.exp_err_i;
      dly   = is_d ? v.dly_d : v.dly_i;
      rd    = is_d ? v.rd_d : v.rd_i;
      addr  = is_d ? v.d_addr : v.i_addr;
      step();
      for (int c = 1; c <= busy; c++) begin
        check("busy_strobes", {30'd0, bus.mem_read, bus.mem_write}, {30'd0, !is_st, is_st});
        check("busy_addr", {16'd0, bus.mem_addr}, {16'd0, addr});
        if (is_st) check("busy_wdata", {16'd0, bus.mem_wdata}, {16'd0, v.d_wdata});
        check("busy_acks_err", {29'd0, bus.i_ack, bus.d_ack, bus.mem_err}, 32'd0);
        check("busy_stalls", {30'd0, bus.stall_if, bus.stall_mem}, {30'd0, bus.i_req, bus.d_req});
        if (c == dly + 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 16'($urandom);
        end
        step();
      end
      if (!err && !is_st) begin
        if (is_d) exp_d_rdata = rd;
        else      exp_i_rdata = rd;
      end
      check("ack_pulse", {30'd0, bus.i_ack, bus.d_ack}, is_d ? 32'd1 : 32'd2);
      check("ack_err", {31'd0, bus.mem_err}, {31'd0, err});
      check("ack_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      check("ack_i_rdata", {16'd0, bus.i_rdata}, {16'd0, exp_i_rdata});
      check("ack_d_rdata", {16'd0, bus.d_rdata}, {16'd0, exp_d_rdata});
      check("ack_stall", {31'd0, is_d ? bus.stall_mem : bus.stall_if}, 32'd0);
      // Ready in an idle cycle must be ignored.
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'($urandom);
      if (is_d) bus.d_req = 1'b0;
      else      bus.i_req = 1'b0;
    end
    step();
    bus.mem_ready = 1'b0;
    check("idle_after", {27'd0, bus.mem_read, bus.mem_write, bus.i_ack, bus.d_ack, bus.mem_err}, 32'd0);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    checks      = 0;
    failures    = 0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    Reset         = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    //            i  d  we  i_addr    d_addr    d_wdata   rd_i      rd_d     dli dld  bi  bd  ei ed
    tbl[0] = mk(1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 0,  0,  1,  0,  0, 0);
    tbl[1] = mk(1, 1, 1, 16'h0040, 16'h0020, 16'h1234, 16'h5A5A, 16'h0000, 0,  0,  1,  1,  0, 0);
    tbl[2] = mk(0, 1, 0, 16'h0000, 16'h0030, 16'h0000, 16'h0000, 16'hBEEF, 0,  3,  0,  4,  0, 0);
    tbl[3] = mk(0, 1, 0, 16'h0000, 16'h0034, 16'h0000, 16'h0000, 16'hDEAD, 0, 20,  0, 15,  0, 1);
    tbl[4] = mk(1, 0, 0, 16'h0050, 16'h0000, 16'h0000, 16'hCAFE, 16'h0000, 14, 0, 15,  0,  0, 0);
    tbl[5] = mk(1, 1, 0, 16'h0060, 16'h0070, 16'h0000, 16'h1111, 16'h2222, 15, 2, 15,  3,  1, 0);

    step();
    check("reset_outputs", {27'd0, bus.mem_read, bus.mem_write, bus.i_ack, bus.d_ack, bus.mem_err}, 32'd0);
    check("reset_data", {bus.i_rdata, bus.d_rdata}, 32'd0);
    check("reset_addr", {bus.mem_addr, bus.mem_wdata}, 32'd0);
    step();
    Reset = 1'b0;
    step();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset in the middle of a store drops the strobe at once and loses the access.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0080; bus.d_wdata = 16'h7777;
    step();
    check("rst_pre_write", {31'd0, bus.mem_write}, 32'd1);
    step();
    #3 Reset = 1'b1;
    #1;
    check("rst_async_strobes", {27'd0, bus.mem_read, bus.mem_write, bus.i_ack, bus.d_ack, bus.mem_err}, 32'd0);
    check("rst_async_addr", {16'd0, bus.mem_addr}, 32'd0);
    bus.d_req = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    step();
    Reset = 1'b0;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_no_ack", {28'd0, bus.mem_read, bus.mem_write, bus.d_ack, bus.mem_err}, 32'd0);
    end
    bus.mem_ready = 1'b0;

    // Fetch request held through its own ack cycle: no regrant until the following edge.
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    step();
    check("hold_first_grant", {15'd0, bus.mem_read, bus.mem_addr}, {15'd0, 1'b1, 16'h0100});
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h0F0F;
    step();
    check("hold_first_ack", {15'd0, bus.i_ack, bus.i_rdata}, {15'd0, 1'b1, 16'h0F0F});
    bus.mem_ready = 1'b0; bus.i_addr = 16'h0102;
    step();
    check("hold_no_regrant", {29'd0, bus.mem_read, bus.i_ack, bus.stall_if}, 32'd1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'hF0F0;
    step();
    check("hold_second_grant", {15'd0, bus.mem_read, bus.mem_addr}, {15'd0, 1'b1, 16'h0102});
    step();
    check("hold_second_ack", {15'd0, bus.i_ack, bus.i_rdata}, {15'd0, 1'b1, 16'hF0F0});
    exp_i_rdata = 16'hF0F0;
    bus.i_req = 1'b0; bus.mem_ready = 1'b0;
    step();
    check("hold_idle", {29'd0, bus.mem_read, bus.i_ack, bus.stall_if}, 32'd0);

    // Randomized accesses against the transaction model.
    for (int r = 0; r < 200; r++) begin
      rv.do_d    = 1'($urandom_range(0, 1));
      rv.do_i    = rv.do_d ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.d_we    = 1'($urandom_range(0, 1));
      rv.i_addr  = 16'($urandom);
      rv.d_addr  = 16'($urandom);
      rv.d_wdata = 16'($urandom);
      rv.rd_i    = 16'($urandom);
      rv.rd_d    = 16'($urandom);
      rv.dly_i   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
      rv.dly_d   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
      rv.exp_busy_i = model_busy(rv.dly_i);
      rv.exp_busy_d = model_busy(rv.dly_d);
      rv.exp_err_i  = model_err(rv.dly_i);
      rv.exp_err_d  = model_err(rv.dly_d);
      run_vec(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
